conv_monitor: RTL
=================

Name: conv_monitor

Overview:
- Synthesizable multi-channel convergence monitor for the flight-control datapath, e.g. watching ptch/roll/yaw against setpoints.
- Each enabled channel must stay within a signed error window of its target for SETTLE consecutive cycles before it counts as converged. A programmable timeout bounds the whole check.
- It sits beside the flight controller and feeds status to the command/response logic and to self-test.
- Generalises the bench's single-shot abs-error check with channel count, width, settle filtering, per-channel enables and abort.

Parameters:
NUM_CH, 3, number of monitored channels
W, 16, width of each signed target/measurement
MARGIN, 10, converged when |meas - target| < MARGIN (strict)
SETTLE, 16, consecutive in-window samples required; must be >= 1
TMO_W, 27, width of timeout counter and tmo_cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches configuration and begins a check
abort  in  1  cancels a check in progress
tmo_cycles  in  TMO_W  timeout length in RUN cycles; sampled on start
ch_en  in  NUM_CH  per-channel enable; sampled on start
targets  in  NUM_CH*W  packed signed targets, channel i at [i*W +: W]; sampled on start
meas  in  NUM_CH*W  packed signed live measurements, same packing, sampled every cycle
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when a check completes (pass or timeout)
pass  out  1  sticky result: all enabled channels converged
tmo_flag  out  1  sticky result: check ended by timeout
conv  out  NUM_CH  sticky per-channel converged flags

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, pass, tmo_flag, conv, all settle counters, timer and latched config = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start: latch targets, ch_en, tmo_cycles; clear conv, pass, tmo_flag, settle counters and timer; go to RUN. busy rises on the same edge.
- start while in RUN is ignored.
- Error arithmetic: err_i = meas_i - target_i, computed sign-extended to W+1 bits, so there is no overflow. Absolute value is taken at W+1 bits. in_win_i = |err_i| < MARGIN.
- Settle counters: one per channel, saturating at SETTLE.
  - Each RUN edge with ch_en_lat[i] and in_win_i: count+1.
  - Any RUN edge with in_win_i low: count cleared to 0.
  - conv[i] sets on the edge where count reaches SETTLE. It is sticky until the next start; later excursions do not clear it.
  - Disabled channels: count stays 0, conv[i] stays 0, and the channel is excluded from completion.
- Timer: increments every RUN edge, starting from 0 on entry.
- Completion is evaluated each RUN edge using registered flags, in this priority:
  1. abort: go to IDLE; busy=0, pass=0, tmo_flag=0, no done pulse; conv holds its partial values.
  2. All enabled channels converged (conv & ch_en_lat == ch_en_lat): go to DONE; done=1 for one cycle; pass=1.
  3. timer == tmo_cycles_lat: go to DONE; done=1 for one cycle; tmo_flag=1; pass=0.
- Simultaneous convergence and timeout on the same edge: pass wins.
- ch_en = 0: completes as pass on the first RUN edge.
- tmo_cycles = 0 with enabled channels: timeout on the first RUN edge.
- Latency, with start at edge 0 and meas already in window:
  - samples are taken at edges 1..SETTLE;
  - conv rises at edge SETTLE;
  - done and pass rise at edge SETTLE+1.
- DONE: busy=0. pass, tmo_flag and conv hold until the next start or reset. done is a one-cycle pulse only.
- abort outside RUN has no effect.

Test Plan:
- SETTLE=4, NUM_CH=3, ch_en=3'b111, targets {0x0066,0x0099,0x00AA}, meas == targets held, tmo=1000, start at edge 0 -> conv=3'b111 at edge 4; done and pass pulse/rise at edge 5; tmo_flag=0.
- Chattering channel: meas0 = target0+9 for 3 cycles, then +10 for 1 cycle, then +9 steady -> conv[0] delayed until 4 consecutive in-window samples after the excursion; a -9 error counts as in-window; ±10 never counts.
- Timeout: meas1 held at target1+50, tmo=20 -> at edge 21 done pulses, tmo_flag=1, pass=0; conv[1]=0 while conv[0] and conv[2] are 1.
- Signed extremes with W=16: target=0x7FFF, meas=0x8000 -> no false in-window from wrap, conv stays 0. Also target=-5, meas=+4 (|err|=9) -> converges.
- ch_en=3'b010 with channels 0 and 2 far off -> pass=1 once channel 1 settles; ch_en=0 -> done and pass at edge 1.
- Corner events:
  - abort mid-RUN -> IDLE, no done pulse, busy low next edge;
  - start pulsed during RUN -> ignored;
  - rst asserted mid-RUN -> all outputs 0 immediately;
  - start issued from DONE -> flags cleared and a new check begins.

Source files
------------

// File: rtl/conv_monitor.sv
// Multi-channel convergence monitor: each enabled channel must hold |meas - target| < MARGIN
// for SETTLE consecutive cycles; a programmable timeout bounds the check.
module conv_monitor #(
  parameter int NUM_CH = 3,
  parameter int W      = 16,
  parameter int MARGIN = 10,
  parameter int SETTLE = 16,
  parameter int TMO_W  = 27
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [TMO_W-1:0]    tmo_cycles,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [NUM_CH*W-1:0] targets,
  input  logic [NUM_CH*W-1:0] meas,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                tmo_flag,
  output logic [NUM_CH-1:0]   conv
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [W:0]    MARGIN_C = (W+1)'(MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH*W-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0]   en_q, en_d;
  logic [TMO_W-1:0]    tmo_lat_q, tmo_lat_d;
  logic [TMO_W-1:0]    timer_q, timer_d;
  logic [CW-1:0]       cnt_q [NUM_CH];
  logic [CW-1:0]       cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   conv_q, conv_d;
  logic                pass_q, pass_d;
  logic                tmof_q, tmof_d;
  logic                done_q, done_d;
  logic [NUM_CH-1:0]   in_win;

  // Error is formed one bit wider than the operands so extreme targets cannot wrap into the window.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_err
    logic signed [W:0] err;
    logic [W:0]        mag;
    assign err = $signed({meas[gi*W+W-1], meas[gi*W +: W]})
               - $signed({tgt_q[gi*W+W-1], tgt_q[gi*W +: W]});
    assign mag = err[W] ? $unsigned(-err) : $unsigned(err);
    assign in_win[gi] = (mag < MARGIN_C);
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    en_d      = en_q;
    tmo_lat_d = tmo_lat_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    conv_d    = conv_q;
    pass_d    = pass_q;
    tmof_d    = tmof_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          tgt_d     = targets;
          en_d      = ch_en;
          tmo_lat_d = tmo_cycles;
          timer_d   = '0;
          conv_d    = '0;
          pass_d    = 1'b0;
          tmof_d    = 1'b0;
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          tmof_d  = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (en_q[i] && in_win[i]) begin
              if (cnt_q[i] != SETTLE_C) cnt_d[i] = cnt_q[i] + 1'b1;
              if (cnt_d[i] == SETTLE_C) conv_d[i] = 1'b1;
            end else begin
              cnt_d[i] = '0;
            end
          end
          // Completion looks at the registered flags, so pass takes priority over a same-edge timeout.
          if ((conv_q & en_q) == en_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (timer_q == tmo_lat_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            tmof_d  = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      en_q      <= '0;
      tmo_lat_q <= '0;
      timer_q   <= '0;
      conv_q    <= '0;
      pass_q    <= 1'b0;
      tmof_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      en_q      <= en_d;
      tmo_lat_q <= tmo_lat_d;
      timer_q   <= timer_d;
      conv_q    <= conv_d;
      pass_q    <= pass_d;
      tmof_q    <= tmof_d;
      done_q    <= done_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign pass     = pass_q;
  assign tmo_flag = tmof_q;
  assign conv     = conv_q;

endmodule
